// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - program counter update with condition evaluation and optional return-address stack
//
// Purpose:
//   Evaluates a 4-bit condition code against the cy/ov/zf/sf flags in the
//   same cycle as the decoded op. On the next ce-qualified clock edge it
//   updates the program counter for NEXT / JMP / CALL / RET.
//
// Configuration:
//   BRANCH_RSTACK_EN  defined   -> LIFO return-address stack of STACK_DEPTH entries.
//                     undefined -> no stack. CALL acts as JMP. A taken RET
//                                  falls through to pc+1 and flags stk_err.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset; takes priority over ce
//   ce       advance enable; all state holds while low
//   op       00 NEXT, 01 JMP, 10 CALL, 11 RET
//   cond     condition code (AL EQ NE CS CC MI PL VS VC GE LT GT LE HI LS NV)
//   target   jump/call destination
//   cy, ov   carry / overflow flags
//   zf, sf   zero / sign flags
//   pc       current program counter
//   flush    one ce-cycle pulse after pc was loaded from target or stack top
//   stk_err  one ce-cycle pulse after a rejected push or pop

module branch_unit #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic [1:0]      op,
    input  logic [3:0]      cond,
    input  logic [PC_W-1:0] target,
    input  logic            cy,
    input  logic            ov,
    input  logic            zf,
    input  logic            sf,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            stk_err
);

    localparam logic [1:0] OP_NEXT = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    logic            taken;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] pc_nxt;
    logic            flush_nxt;
    logic            err_nxt;

    // Sequential address wraps naturally at 2^PC_W.
    assign seq = pc + PC_W'(1);

    // Condition evaluation from the flags presented alongside op.
    always_comb begin
        taken = 1'b0;
        case (cond)
            4'h0: taken = 1'b1;
            4'h1: taken = zf;
            4'h2: taken = ~zf;
            4'h3: taken = cy;
            4'h4: taken = ~cy;
            4'h5: taken = sf;
            4'h6: taken = ~sf;
            4'h7: taken = ov;
            4'h8: taken = ~ov;
            4'h9: taken = (sf == ov);
            4'hA: taken = (sf != ov);
            4'hB: taken = ~zf & (sf == ov);
            4'hC: taken = zf | (sf != ov);
            4'hD: taken = cy & ~zf;
            4'hE: taken = ~cy | zf;
            4'hF: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

`ifdef BRANCH_RSTACK_EN

    // sp counts 0..STACK_DEPTH, so it needs one more code than the index.
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]  sp;
    logic [PC_W-1:0]  stack [STACK_DEPTH];
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             push;
    logic             pop;

    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    // Truncation is harmless: push_idx is only used when not full,
    // top_idx only when not empty.
    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_W'(1));

    always_comb begin
        pc_nxt    = seq;
        flush_nxt = 1'b0;
        err_nxt   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        case (op)
            OP_NEXT: pc_nxt = seq;
            OP_JMP: begin
                if (taken) begin
                    pc_nxt    = target;
                    flush_nxt = 1'b1;
                end
            end
            OP_CALL: begin
                if (taken) begin
                    if (!full) begin
                        push      = 1'b1;
                        pc_nxt    = target;
                        flush_nxt = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            OP_RET: begin
                if (taken) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        pc_nxt    = stack[top_idx];
                        flush_nxt = 1'b1;
                    end else begin
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: pc_nxt = seq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (ce) begin
            if (push) begin
                sp <= sp + SP_W'(1);
            end else if (pop) begin
                sp <= sp - SP_W'(1);
            end
        end
    end

    // Stack contents are not reset; only sp defines what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && ce && push) begin
            stack[push_idx] <= seq;
        end
    end

`else

    always_comb begin
        pc_nxt    = seq;
        flush_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (op)
            OP_NEXT: pc_nxt = seq;
            OP_JMP, OP_CALL: begin
                if (taken) begin
                    pc_nxt    = target;
                    flush_nxt = 1'b1;
                end
            end
            OP_RET: begin
                // Nothing to return to: fall through and report.
                if (taken) begin
                    err_nxt = 1'b1;
                end
            end
            default: pc_nxt = seq;
        endcase
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= '0;
            flush   <= 1'b0;
            stk_err <= 1'b0;
        end else if (ce) begin
            pc      <= pc_nxt;
            flush   <= flush_nxt;
            stk_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit
module tb_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] cond = 4'h0;
    logic [7:0] target = 8'h00;
    logic       cy = 1'b0;
    logic       ov = 1'b0;
    logic       zf = 1'b0;
    logic       sf = 1'b0;
    logic [7:0] pc;
    logic       flush;
    logic       stk_err;

    branch_unit #(.PC_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .op(op), .cond(cond),
        .target(target), .cy(cy), .ov(ov), .zf(zf), .sf(sf),
        .pc(pc), .flush(flush), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic       err;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0;
    int         total = 0;

    // Reference state
    int         m_pc = 0;
    logic       m_flush = 1'b0;
    logic       m_err = 1'b0;
    int         m_stk[$];

    function automatic bit cond_true(input int c, input bit fcy, input bit fov,
                                     input bit fzf, input bit fsf);
        bit ge;
        ge = (fsf == fov);
        case (c)
            0:  return 1;
            1:  return fzf;
            2:  return !fzf;
            3:  return fcy;
            4:  return !fcy;
            5:  return fsf;
            6:  return !fsf;
            7:  return fov;
            8:  return !fov;
            9:  return ge;
            10: return !ge;
            11: return !fzf && ge;
            12: return fzf || !ge;
            13: return fcy && !fzf;
            14: return !fcy || fzf;
            default: return 0;
        endcase
    endfunction

    // Apply one cycle of stimulus and record what the next edge must produce.
    task automatic step(input bit r, input bit c, input int o, input int cd,
                        input int tg, input int flags, input string tag);
        bit t;
        int nxt;
        exp_t e;
        @(negedge clk);
        rst_n  = r;
        ce     = c;
        op     = 2'(o);
        cond   = 4'(cd);
        target = 8'(tg);
        cy     = flags[3];
        ov     = flags[2];
        zf     = flags[1];
        sf     = flags[0];
        if (!r) begin
            m_pc = 0; m_flush = 0; m_err = 0;
            m_stk.delete();
        end else if (c) begin
            t   = cond_true(cd, flags[3], flags[2], flags[1], flags[0]);
            nxt = (m_pc + 1) % 256;
            m_flush = 0;
            m_err   = 0;
            if (o == 0 || !t) begin
                m_pc = nxt;
            end else if (o == 1) begin
                m_pc = tg; m_flush = 1;
            end else if (o == 2) begin
`ifdef BRANCH_RSTACK_EN
                if (m_stk.size() < 4) begin
                    m_stk.push_back(nxt); m_pc = tg; m_flush = 1;
                end else begin
                    m_pc = nxt; m_err = 1;
                end
`else
                m_pc = tg; m_flush = 1;
`endif
            end else begin
`ifdef BRANCH_RSTACK_EN
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back(); m_flush = 1;
                end else begin
                    m_pc = nxt; m_err = 1;
                end
`else
                m_pc = nxt; m_err = 1;
`endif
            end
        end
        e.pc = 8'(m_pc); e.flush = m_flush; e.err = m_err; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: every edge produces one observable result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (pc === e.pc && flush === e.flush && stk_err === e.err)
                passed++;
            else
                $display("FAIL %s: got pc=%02h flush=%b stk_err=%b, want pc=%02h flush=%b stk_err=%b",
                         e.tag, pc, flush, stk_err, e.pc, e.flush, e.err);
        end
    end

    initial begin
        // Reset with a taken JMP pending: reset must win.
        step(0, 1, 1, 0, 8'h55, 0, "reset0");
        step(0, 1, 1, 0, 8'h55, 0, "reset1");

        // Sequential wrap
        step(1, 1, 1, 0, 8'hFE, 0, "jmp_fe");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, "wrap");

        // Condition sweep
        for (int c = 0; c < 16; c++)
            for (int f = 0; f < 16; f++)
                step(1, 1, 1, c, 8'hA0, f, "cond");

        // Call / return chain
        step(1, 1, 1, 0, 8'h10, 0, "to10");
        step(1, 1, 2, 0, 8'h40, 0, "call40");
        step(1, 1, 2, 0, 8'h80, 0, "call80");
        step(1, 1, 3, 0, 0, 0, "ret41");
        step(1, 1, 3, 0, 0, 0, "ret11");

        // Stack bounds
        step(0, 1, 0, 0, 0, 0, "rst_b");
        for (int i = 0; i < 5; i++) step(1, 1, 2, 0, 8'h20 + i * 8'h10, 0, "call_bound");
        for (int i = 0; i < 5; i++) step(1, 1, 3, 0, 0, 0, "ret_bound");
        step(1, 1, 0, 0, 0, 0, "err_clear");

        // Untaken CALL/RET leave stack and error alone
        step(1, 1, 2, 15, 8'h33, 0, "call_nv");
        step(1, 1, 3, 15, 0, 0, "ret_nv");

        // ce gating, including held flush and held stk_err
        step(1, 1, 1, 0, 8'h77, 0, "pre_gate");
        step(1, 0, 1, 0, 8'h99, 0, "gate_flush");
        step(1, 1, 3, 0, 0, 0, "ret_empty");
        step(1, 0, 1, 0, 8'h99, 0, "gate_err");
        step(1, 1, 1, 0, 8'h99, 0, "ungated");

        // Reset mid-sequence discards stack
        step(1, 1, 2, 0, 8'h50, 0, "call_pre_rst");
        step(0, 1, 0, 0, 0, 0, "rst_mid");
        step(1, 1, 3, 0, 0, 0, "ret_after_rst");

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3), $urandom_range(0, 15),
                 $urandom_range(0, 255), $urandom_range(0, 15), "random");

        @(posedge clk);
        #2;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending, want 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
